// File: rtl/io_pkg.sv
// io_pkg: shared constants, types and helpers for the board I/O port.
// Register offsets are byte offsets inside the 32-byte window.
package io_pkg;

    localparam logic [4:0] OFF_KEY_STATE = 5'h00;
    localparam logic [4:0] OFF_KEY_EVENT = 5'h04;
    localparam logic [4:0] OFF_SW_STATE  = 5'h08;
    localparam logic [4:0] OFF_LED       = 5'h0C;
    localparam logic [4:0] OFF_HEX       = 5'h10;
    localparam logic [4:0] OFF_HEX_EN    = 5'h14;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        DB_STABLE,
        DB_COUNTING
    } db_state_t;

    // Active-low {g,f,e,d,c,b,a} hex digit patterns.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// io_debounce: two-flop synchroniser plus counter debounce for one
// active-low pushbutton; flags the cycle a press is accepted.
module io_debounce
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic stable,
    output logic press_pulse
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    db_state_t        state_q;
    db_state_t        state_d;

    // Synchroniser resets to the released level so a held key reads as a new press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= DB_STABLE;
        end else begin
            sync_q1 <= async_in;
            sync_q2 <= sync_q1;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        level_d     = level_q;
        press_pulse = 1'b0;
        unique case (state_q)
            DB_STABLE: begin
                if (sync_q2 != level_q) begin
                    if (cnt_q == LAST) begin
                        level_d     = sync_q2;
                        cnt_d       = '0;
                        press_pulse = level_q;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = DB_COUNTING;
                    end
                end
            end
            DB_COUNTING: begin
                if (sync_q2 == level_q) begin
                    cnt_d   = '0;
                    state_d = DB_STABLE;
                end else if (cnt_q == LAST) begin
                    level_d     = sync_q2;
                    cnt_d       = '0;
                    state_d     = DB_STABLE;
                    press_pulse = level_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    assign stable = level_q;

endmodule

// File: rtl/io_port_unit.sv
// io_port_unit: memory-mapped KEY/SW/LED/7-segment peripheral.
// Decodes a 32-byte window, holds output registers, latches key presses.
module io_port_unit
    import io_pkg::*;
#(
    parameter logic [31:0] IO_BASE         = 32'hFFFF_FF00,
    parameter int          DEBOUNCE_CYCLES = 8,
    parameter int          CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        sel,
    input  logic [3:0]  KEY,
    input  logic [9:0]  SW,
    output logic [9:0]  LED,
    output logic [6:0]  SEG0,
    output logic [6:0]  SEG1,
    output logic [6:0]  SEG2,
    output logic [6:0]  SEG3,
    output logic [6:0]  SEG4,
    output logic [6:0]  SEG5
);

    logic [3:0]  key_level;
    logic [3:0]  key_press;
    logic [3:0]  key_state;
    logic [3:0]  key_event_q;
    logic [3:0]  w1c_mask;
    logic [9:0]  sw_q1;
    logic [9:0]  sw_q2;
    logic [9:0]  led_q;
    logic [23:0] hex_q;
    logic [5:0]  hex_en_q;
    logic [4:0]  off;
    logic        wr;
    logic [6:0]  seg [6];
    logic        unused_bits;

    for (genvar i = 0; i < 4; i++) begin : g_key
        io_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clock      (clock),
            .reset      (reset),
            .async_in   (KEY[i]),
            .stable     (key_level[i]),
            .press_pulse(key_press[i])
        );
    end

    assign key_state   = ~key_level;
    assign sel         = (addr[31:5] == IO_BASE[31:5]);
    assign off         = {addr[4:2], 2'b00};
    assign wr          = we && sel;
    assign w1c_mask    = (wr && off == OFF_KEY_EVENT) ? wdata[3:0] : 4'h0;
    assign unused_bits = ^{addr[1:0], wdata[31:24]};

    // Press set is applied after the clear so a coincident W1C loses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_q1       <= '0;
            sw_q2       <= '0;
            key_event_q <= '0;
            led_q       <= '0;
            hex_q       <= '0;
            hex_en_q    <= '0;
        end else begin
            sw_q1       <= SW;
            sw_q2       <= sw_q1;
            key_event_q <= (key_event_q & ~w1c_mask) | key_press;
            if (wr && off == OFF_LED)    led_q    <= wdata[9:0];
            if (wr && off == OFF_HEX)    hex_q    <= wdata[23:0];
            if (wr && off == OFF_HEX_EN) hex_en_q <= wdata[5:0];
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (off)
                OFF_KEY_STATE: rdata = {28'h0, key_state};
                OFF_KEY_EVENT: rdata = {28'h0, key_event_q};
                OFF_SW_STATE:  rdata = {22'h0, sw_q2};
                OFF_LED:       rdata = {22'h0, led_q};
                OFF_HEX:       rdata = {8'h0, hex_q};
                OFF_HEX_EN:    rdata = {26'h0, hex_en_q};
                default:       rdata = '0;
            endcase
        end
    end

    always_comb begin
        for (int n = 0; n < 6; n++) begin
            seg[n] = hex_en_q[n] ? seg7(hex_q[4*n +: 4]) : SEG_BLANK;
        end
    end

    assign LED  = led_q;
    assign SEG0 = seg[0];
    assign SEG1 = seg[1];
    assign SEG2 = seg[2];
    assign SEG3 = seg[3];
    assign SEG4 = seg[4];
    assign SEG5 = seg[5];

endmodule
